// File: rtl/hmac_msg_loader_pkg.sv
// Shared constants, state encoding and byte helpers for the HMAC message loader.
package hmac_msg_loader_pkg;

  localparam int RATE_BYTES = 136;
  localparam int KEY_BITS   = 128;
  localparam int MAC_BITS   = 256;
  localparam int BLOCK_BITS = 8 * RATE_BYTES;
  localparam int IDX_W      = $clog2(BLOCK_BITS);
  localparam int CNT_W      = 8;

  localparam logic [CNT_W-1:0] MAX_MSG_BYTES = 8'd135;
  localparam logic [7:0]       SHA3_DS_BYTE  = 8'h06;
  localparam logic [7:0]       SHA3_END_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_PAD     = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUT     = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  // The core consumes each byte LSB-first from the high end of its slot.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/hmac_msg_loader_pad_block.sv
// Combinational pad10*1 with the SHA3 domain byte: maps the raw collected
// buffer and its byte count to the final rate block.
module sha3_pad_block
  import hmac_msg_loader_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] raw,
  input  logic [CNT_W-1:0]      cnt,
  output logic [BLOCK_BITS-1:0] padded
);

  always_comb begin
    padded = raw;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (cnt == CNT_W'(k)) begin
        padded[(RATE_BYTES-1-k)*8 +: 8] = raw[(RATE_BYTES-1-k)*8 +: 8] | bit_rev8(SHA3_DS_BYTE);
      end
    end
    // Final rate byte always carries the closing pad bit; it merges with the
    // domain byte when the message fills all but the last slot.
    padded[7:0] = padded[7:0] | bit_rev8(SHA3_END_BYTE);
  end

endmodule

// File: rtl/hmac_msg_loader.sv
// Byte-stream front end for the HMAC-SHA3-256 core: collects one padded rate
// block, launches the core, and hands the resulting MAC downstream.
module hmac_msg_loader
  import hmac_msg_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_BITS-1:0]   key_in,
  input  logic                  key_load,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic [BLOCK_BITS-1:0] msg_out,
  output logic [KEY_BITS-1:0]   key_out,
  output logic                  hmac_start,
  input  logic                  hmac_ready,
  input  logic [MAC_BITS-1:0]   hmac_mac,
  output logic [MAC_BITS-1:0]   mac_out,
  output logic                  mac_valid,
  input  logic                  mac_accept,
  output logic                  err_overflow
);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [BLOCK_BITS-1:0] blk;
  logic [BLOCK_BITS-1:0] padded;
  logic [KEY_BITS-1:0]   key_reg;
  logic [MAC_BITS-1:0]   mac_reg;
  logic [IDX_W-1:0]      wr_lsb;
  logic                  accept_byte;
  logic                  overflow;

  sha3_pad_block u_pad (
    .raw    (blk),
    .cnt    (cnt),
    .padded (padded)
  );

  assign wr_lsb      = IDX_W'((RATE_BYTES - 1 - int'(cnt)) * 8);
  assign accept_byte = in_valid && in_ready;
  assign overflow    = (state == ST_COLLECT) && accept_byte && (cnt == MAX_MSG_BYTES);

  assign msg_out = blk;
  assign key_out = key_reg;
  assign mac_out = mac_reg;

  // The block register doubles as the collection buffer and the core's
  // message input, so it stays frozen from PAD until the MAC is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_COLLECT;
      cnt          <= '0;
      blk          <= '0;
      key_reg      <= '0;
      mac_reg      <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      err_overflow <= overflow;
      case (state)
        ST_COLLECT: begin
          if (key_load) key_reg <= key_in;
          if (overflow) begin
            blk <= '0;
            cnt <= '0;
          end else if (accept_byte) begin
            blk[wr_lsb +: 8] <= bit_rev8(in_data);
            cnt              <= cnt + 8'd1;
          end
        end
        ST_PAD:  blk <= padded;
        ST_WAIT: if (hmac_ready) mac_reg <= hmac_mac;
        ST_OUT: begin
          if (mac_accept) begin
            blk <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    hmac_start = 1'b0;
    mac_valid  = 1'b0;
    case (state)
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A 136th byte can never fit with padding; a last one needs no drain.
          if (cnt == MAX_MSG_BYTES) state_n = in_last ? ST_COLLECT : ST_DRAIN;
          else if (in_last)         state_n = ST_PAD;
        end
      end
      ST_PAD:   state_n = ST_START;
      ST_START: begin
        hmac_start = 1'b1;
        state_n    = ST_WAIT;
      end
      ST_WAIT:  if (hmac_ready) state_n = ST_OUT;
      ST_OUT: begin
        mac_valid = 1'b1;
        if (mac_accept) state_n = ST_COLLECT;
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_n = ST_COLLECT;
      end
      default:  state_n = ST_COLLECT;
    endcase
  end

endmodule
